// File: rtl/led_pattern_gen.sv
// Active-low LED pattern generator: a tick divider plus eight static or animated patterns
// selected by a 3-bit mode.
module led_pattern_gen #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned LED_N   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             pause,
  output logic [LED_N-1:0] led_out,
  output logic             tick
);

  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned POS_W  = $clog2(LED_N);
  localparam int unsigned FILL_W = $clog2(LED_N + 1);

  localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(DIV - 1);
  localparam logic [POS_W-1:0]  PosMax  = POS_W'(LED_N - 1);
  localparam logic [FILL_W-1:0] FillMax = FILL_W'(LED_N);

  typedef enum logic [2:0] {
    ModeOff, ModeOn, ModeBlink, ModeRunUp, ModeRunDn, ModePing, ModeBar, ModeBin
  } mode_e;

  mode_e             r_mode;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [POS_W-1:0]  r_pos, w_pos_d;
  logic              r_dir, w_dir_d;
  logic [FILL_W-1:0] r_fill, w_fill_d;
  logic [LED_N-1:0]  r_bcnt, w_bcnt_d;
  logic              r_blink, w_blink_d;
  logic [LED_N-1:0]  r_led, w_img;
  logic              w_tick, w_mode_chg;

  assign w_tick     = (r_cnt == CntMax) && !pause;
  assign w_mode_chg = (mode != r_mode);
  assign tick       = w_tick;
  assign led_out    = r_led;

  // A mode change reloads the pattern and restarts the divider, overriding any coincident step.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_pos_d   = r_pos;
    w_dir_d   = r_dir;
    w_fill_d  = r_fill;
    w_bcnt_d  = r_bcnt;
    w_blink_d = r_blink;
    if (w_mode_chg) begin
      w_cnt_d   = '0;
      w_pos_d   = (mode_e'(mode) == ModeRunDn) ? PosMax : '0;
      w_dir_d   = 1'b0;
      w_fill_d  = '0;
      w_bcnt_d  = '0;
      w_blink_d = 1'b1;
    end else if (!pause) begin
      w_cnt_d = (r_cnt == CntMax) ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        unique case (r_mode)
          ModeBlink: w_blink_d = ~r_blink;
          ModeRunUp: w_pos_d = (r_pos == PosMax) ? '0 : r_pos + 1'b1;
          ModeRunDn: w_pos_d = (r_pos == '0) ? PosMax : r_pos - 1'b1;
          ModePing: begin
            // dir=0 moves up; ends flip direction so each end is lit for a single step
            if (!r_dir) begin
              if (r_pos == PosMax) begin
                w_dir_d = 1'b1;
                w_pos_d = r_pos - 1'b1;
              end else begin
                w_pos_d = r_pos + 1'b1;
              end
            end else begin
              if (r_pos == '0) begin
                w_dir_d = 1'b0;
                w_pos_d = r_pos + 1'b1;
              end else begin
                w_pos_d = r_pos - 1'b1;
              end
            end
          end
          ModeBar:   w_fill_d = (r_fill == FillMax) ? '0 : r_fill + 1'b1;
          ModeBin:   w_bcnt_d = r_bcnt + 1'b1;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_img = '0;
    unique case (r_mode)
      ModeOff:   w_img = '0;
      ModeOn:    w_img = '1;
      ModeBlink: w_img = {LED_N{r_blink}};
      ModeRunUp, ModeRunDn, ModePing: begin
        for (int i = 0; i < int'(LED_N); i++) w_img[i] = (r_pos == POS_W'(i));
      end
      ModeBar: begin
        for (int i = 0; i < int'(LED_N); i++) w_img[i] = (FILL_W'(i) < r_fill);
      end
      ModeBin:   w_img = r_bcnt;
      default:   w_img = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= ModeOff;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_fill  <= '0;
      r_bcnt  <= '0;
      r_blink <= 1'b0;
      r_led   <= '1;
    end else begin
      r_mode  <= mode_e'(mode);
      r_cnt   <= w_cnt_d;
      r_pos   <= w_pos_d;
      r_dir   <= w_dir_d;
      r_fill  <= w_fill_d;
      r_bcnt  <= w_bcnt_d;
      r_blink <= w_blink_d;
      r_led   <= ~w_img;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues expected LED images and tick times,
// a monitor compares them as the DUT output changes.
module tb_led_pattern_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       pause = 1'b0;
  logic [2:0] mode  = 3'd0;
  logic [3:0] led_out;
  logic       tick;

  led_pattern_gen #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .LED_N  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .pause  (pause),
    .led_out(led_out),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] led;
    int         at;
  } exp_t;

  exp_t       led_q[$];
  int         tick_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         mon_en  = 1'b0;
  bit         tick_en = 1'b0;
  logic [3:0] prev_led;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_led(input logic [3:0] v, input int at);
    exp_t e;
    e.led = v;
    e.at  = at;
    led_q.push_back(e);
  endtask

  // Monitor: every LED change must match the next queued image at the queued cycle.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (led_out !== prev_led) begin
        if (led_q.size() == 0) begin
          chk("unexpected_led_change", led_out, prev_led);
        end else begin
          e = led_q.pop_front();
          chk("led_value", led_out, e.led);
          chk("led_cycle", cyc, e.at);
        end
        prev_led = led_out;
      end
      if (tick_en && tick === 1'b1) begin
        if (tick_q.size() == 0) chk("unexpected_tick", tick, 0);
        else chk("tick_cycle", cyc, tick_q.pop_front());
      end
    end
  end

  initial begin
    int c;
    #1;
    rst_n = 1'b0;
    mode  = 3'd3;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_led", led_out, 4'hF);
    chk("reset_tick", tick, 0);
    prev_led = 4'hF;
    mon_en   = 1'b1;
    mode     = 3'd0;

    // Mode 0 after reset release: dark, ticks every 10 clocks
    @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    tick_en = 1'b1;
    tick_q.push_back(c + 9);
    tick_q.push_back(c + 19);
    tick_q.push_back(c + 29);
    repeat (31) @(negedge clk);
    tick_en = 1'b0;
    chk("mode0_led", led_out, 4'hF);

    // Run-up
    c = cyc;
    mode = 3'd3;
    push_led(4'b1110, c + 2);
    push_led(4'b1101, c + 12);
    push_led(4'b1011, c + 22);
    push_led(4'b0111, c + 32);
    push_led(4'b1110, c + 42);
    push_led(4'b1101, c + 52);
    repeat (53) @(negedge clk);

    // Ping-pong
    c = cyc;
    mode = 3'd5;
    push_led(4'b1110, c + 2);
    push_led(4'b1101, c + 12);
    push_led(4'b1011, c + 22);
    push_led(4'b0111, c + 32);
    push_led(4'b1011, c + 42);
    push_led(4'b1101, c + 52);
    push_led(4'b1110, c + 62);
    push_led(4'b1101, c + 72);
    repeat (73) @(negedge clk);

    // Bar, then switch to binary on a tick clock
    c = cyc;
    mode = 3'd6;
    push_led(4'b1111, c + 2);
    push_led(4'b1110, c + 12);
    push_led(4'b1100, c + 22);
    push_led(4'b1000, c + 32);
    push_led(4'b0000, c + 42);
    push_led(4'b1111, c + 52);
    repeat (60) @(negedge clk);
    #1;
    chk("tick_at_mode_change", tick, 1);
    mode = 3'd7;
    push_led(4'b1110, c + 72);
    repeat (15) @(negedge clk);

    // Pause with cnt == 4 for 25 clocks
    pause = 1'b1;
    tick_en = 1'b1;
    tick_q.push_back(c + 105);
    repeat (25) @(negedge clk);
    chk("pause_led_frozen", led_out, 4'b1110);
    pause = 1'b0;
    push_led(4'b1101, c + 107);
    push_led(4'b1100, c + 117);
    repeat (8) @(negedge clk);
    tick_en = 1'b0;
    repeat (10) @(negedge clk);

    // Blink with asynchronous reset mid-run
    c = cyc;
    mode = 3'd2;
    push_led(4'b0000, c + 2);
    push_led(4'b1111, c + 12);
    push_led(4'b0000, c + 22);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    push_led(4'b1111, c + 25);
    #1;
    chk("async_reset_led", led_out, 4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_led(4'b0000, c + 30);
    push_led(4'b1111, c + 40);
    push_led(4'b0000, c + 50);
    repeat (24) @(negedge clk);

    chk("led_queue_empty", led_q.size(), 0);
    chk("tick_queue_empty", tick_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
